prim_subst_perm_iter: RTL
=========================

# prim_subst_perm_iter

Iterative, handshaked successor to the combinational PRESENT-style substitution-permutation primitive. It computes the same round function over a configurable number of rounds. `RoundsPerCycle` unrolled rounds are evaluated per clock, so the designer trades area against latency. Encrypt or decrypt is selected per transaction at run time rather than by parameter. The block sits between a requester (scrambling or address-obfuscation logic) and its consumer, with valid/ready flow control on both sides.

## Interface
- `DataWidth`, 64: block width in bits; multiple of 4, at least 8.
- `NumRounds`, 31: total rounds; at least 1.
- `RoundsPerCycle`, 1: rounds evaluated per clock; must divide `NumRounds` exactly (elaboration-time assertion).
- `clk_i` in 1: clock; single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: block can accept a request.
- `decrypt_i` in 1: 0 selects encrypt, 1 selects decrypt; sampled at accept.
- `data_i` in DataWidth: plaintext or ciphertext; sampled at accept.
- `key_i` in DataWidth: round key, the same for every round; sampled at accept.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts result.
- `data_o` out DataWidth: result; held stable while `out_valid_o`=1.
- `busy_o` out 1: high in RUN and DONE.

## Operation
- Round function, with W = DataWidth and s = state ^ key:
  - PRESENT S-box, index 0..15: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - Inverse S-box: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
  - Encrypt round: apply the S-box to every nibble of s. Bit-reverse, so bit k moves to W-1-k. Unshuffle: out[k]=in[2k], out[k+W/2]=in[2k+1], for k<W/2.
  - Decrypt round: shuffle first: f[2k]=s[k], f[2k+1]=s[k+W/2]. Bit-reverse. Apply the inverse S-box to every nibble.
  - Final result = state after `NumRounds` rounds ^ key.
  - Decrypt with the same key and round count inverts encrypt exactly.
- State machine:
  - IDLE: `in_ready_o`=1. On `in_valid_i`&&`in_ready_o`, latch data, key and mode; clear the round counter; go to RUN.
  - RUN: each cycle, apply `RoundsPerCycle` rounds to the state register and add `RoundsPerCycle` to the counter. When the counter reaches `NumRounds`, register `data_o` = state ^ key and go to DONE.
  - DONE: `out_valid_o`=1. On `out_ready_i`, go to IDLE. If `in_valid_i` is high in the same cycle, accept the new request directly into RUN. In DONE, `in_ready_o` = `out_ready_i`.
- Round counter width: $clog2(NumRounds+1). It never exceeds `NumRounds` and does not wrap.
- Inputs are ignored outside IDLE and outside the DONE-and-`out_ready_i` case. Changes to `data_i`, `key_i` or `decrypt_i` after accept do not affect the result.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready_o`=0 during reset, 1 from the first cycle after reset deasserts.
  - `out_valid_o`=0 and `busy_o`=0.
  - `data_o`=0.
  - Counter=0.
- Latency from the accept edge to `out_valid_o` high is L = `NumRounds`/`RoundsPerCycle` cycles.
- Throughput is one result per L+1 cycles with `out_ready_i` tied high. There is no idle bubble between transactions.
- Backpressure: `out_valid_o` and `data_o` hold indefinitely while `out_ready_i`=0. No new request is accepted during that time.
- Reset asserted in RUN or DONE: return to IDLE on the next edge and drop `out_valid_o` with no handshake. The result in flight is discarded.
- `out_ready_i` without `out_valid_o` has no effect.

## Test plan
- DataWidth=8, NumRounds=1, encrypt, data=0x00, key=0x00 -> one cycle after accept, `out_valid_o`=1 with `data_o`=0x55.
- Same configuration, decrypt, data=0x55, key=0x00 -> `data_o`=0x00.
- 64/31 configuration: 1000 random data/key pairs, encrypt then decrypt -> decrypt output equals the original data. Every result matches the reference-model round function.
- Same random stream run with RoundsPerCycle=1 and RoundsPerCycle=31 -> identical `data_o` sequence. Latencies are 31 and 1 cycles respectively.
- Hold `out_ready_i`=0 for 10 cycles in DONE while `in_valid_i`=1 -> `in_ready_o`=0 and `data_o` is stable. Release `out_ready_i` -> the result is consumed and the new request is accepted on the same edge.
- Assert `rst_i` at round 15 of 31 -> next cycle: IDLE, `out_valid_o`=0, `busy_o`=0. The following transaction produces the correct result.

Source files
------------

// File: rtl/prim_subst_perm_iter_if.sv
// Request/response bundle of the iterative substitution-permutation primitive.
// Member names carry the direction as seen from the primitive (slave side).
interface prim_subst_perm_iter_if #(
  parameter int DataWidth = 64
) ();
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic                 decrypt_i;
  logic [DataWidth-1:0] data_i;
  logic [DataWidth-1:0] key_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DataWidth-1:0] data_o;
  logic                 busy_o;

  modport master (
    output in_valid_i, decrypt_i, data_i, key_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, busy_o
  );

  modport slave (
    input  in_valid_i, decrypt_i, data_i, key_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, busy_o
  );
endinterface

// File: rtl/prim_subst_perm_iter.sv
// Iterative PRESENT-style substitution-permutation primitive with valid/ready
// handshakes; RoundsPerCycle unrolled rounds are applied per clock.
module prim_subst_perm_iter #(
  parameter int DataWidth      = 64,
  parameter int NumRounds      = 31,
  parameter int RoundsPerCycle = 1
) (
  input logic                    clk_i,
  input logic                    rst_i,
  prim_subst_perm_iter_if.slave  io
);

  localparam int CntW = $clog2(NumRounds + 1);
  localparam logic [CntW-1:0] Step    = CntW'(RoundsPerCycle);
  localparam logic [CntW-1:0] LastCnt = CntW'(NumRounds);

  if (RoundsPerCycle < 1) begin : gen_bad_rpc_min
    $error("RoundsPerCycle must be at least 1");
  end else if ((NumRounds % RoundsPerCycle) != 0) begin : gen_bad_rpc_div
    $error("RoundsPerCycle must divide NumRounds");
  end
  if ((DataWidth % 4) != 0 || DataWidth < 8 || NumRounds < 1) begin : gen_bad_dims
    $error("DataWidth must be a multiple of 4 and >= 8; NumRounds >= 1");
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [DataWidth-1:0] enc_round(input logic [DataWidth-1:0] st,
                                                     input logic [DataWidth-1:0] key);
    logic [DataWidth-1:0] s, rv, r;
    s  = st ^ key;
    rv = '0;
    r  = '0;
    for (int n = 0; n < DataWidth / 4; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
    for (int k = 0; k < DataWidth; k++) rv[DataWidth-1-k] = s[k];
    for (int k = 0; k < DataWidth / 2; k++) begin
      r[k]               = rv[2*k];
      r[k+DataWidth/2]   = rv[2*k+1];
    end
    return r;
  endfunction

  function automatic logic [DataWidth-1:0] dec_round(input logic [DataWidth-1:0] st,
                                                     input logic [DataWidth-1:0] key);
    logic [DataWidth-1:0] s, f, rv;
    s  = st ^ key;
    f  = '0;
    rv = '0;
    for (int k = 0; k < DataWidth / 2; k++) begin
      f[2*k]   = s[k];
      f[2*k+1] = s[k+DataWidth/2];
    end
    for (int k = 0; k < DataWidth; k++) rv[DataWidth-1-k] = f[k];
    for (int n = 0; n < DataWidth / 4; n++) rv[4*n +: 4] = sbox_inv(rv[4*n +: 4]);
    return rv;
  endfunction

  // IDLE: wait for a request | RUN: iterate rounds | DONE: hold result for the consumer
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               fsm_q, fsm_d;
  logic [DataWidth-1:0] blk_q, blk_d;
  logic [DataWidth-1:0] key_q, key_d;
  logic                 dec_q, dec_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] res_q, res_d;
  logic [DataWidth-1:0] round_out;
  logic                 in_ready, out_valid, busy;

  always_comb begin
    round_out = blk_q;
    for (int r = 0; r < RoundsPerCycle; r++) begin
      round_out = dec_q ? dec_round(round_out, key_q) : enc_round(round_out, key_q);
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    blk_d     = blk_q;
    key_d     = key_q;
    dec_d     = dec_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        busy  = 1'b1;
        blk_d = round_out;
        cnt_d = cnt_q + Step;
        if (cnt_d == LastCnt) begin
          res_d = round_out ^ key_q;
          fsm_d = StDone;
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = io.out_ready_i;
        if (io.out_ready_i) fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
    // A request accepted in DONE goes straight to RUN, so there is no idle bubble.
    if (in_ready && io.in_valid_i) begin
      fsm_d = StRun;
      blk_d = io.data_i;
      key_d = io.key_i;
      dec_d = io.decrypt_i;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q <= StIdle;
      blk_q <= '0;
      key_q <= '0;
      dec_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      blk_q <= blk_d;
      key_q <= key_d;
      dec_q <= dec_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end

  assign io.in_ready_o  = in_ready & ~rst_i;
  assign io.out_valid_o = out_valid;
  assign io.busy_o      = busy;
  assign io.data_o      = res_q;

endmodule
